// File: rtl/eep_arbiter_pkg.sv
// Shared definitions for the EEPROM access sequencer. These cover the state encoding,
// the requester source, the data and address widths, and the EEPROM address map.
package eep_arbiter_pkg;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 2;

  // EEPROM word map
  localparam logic [ADDR_W-1:0] ADDR_XSET = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_P    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_I    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_D    = 2'd3;

  // ST_VFY is only reachable when write verify is built in
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_REC  = 3'd3,
    ST_VFY  = 3'd4
  } state_e;

  typedef enum logic {
    SRC_LOOP = 1'b0,
    SRC_CMD  = 1'b1
  } src_e;

endpackage

// File: rtl/eep_arbiter_if.sv
// Requester handshakes and EEPROM pin bundle for eep_arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding system's view.
// Optional: EEP_WR_VERIFY_EN adds the wr_err status line.
interface eep_arbiter_if;
  import eep_arbiter_pkg::*;

  logic              p_req;
  logic [ADDR_W-1:0] p_addr;
  logic              p_gnt;
  logic              p_vld;
  logic [DATA_W-1:0] p_rdata;

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_done;
  logic [DATA_W-1:0] c_rdata;

  logic [ADDR_W-1:0] eep_addr;
  logic [DATA_W-1:0] eep_wdata;
  logic [DATA_W-1:0] eep_rdata;
  logic              eep_cs_n;
  logic              eep_r_w_n;
  logic              chrg_pmp_en;
  logic              busy;
`ifdef EEP_WR_VERIFY_EN
  logic              wr_err;
`endif

  modport slave (
    input  p_req, p_addr, c_req, c_we, c_addr, c_wdata, eep_rdata,
    output p_gnt, p_vld, p_rdata, c_gnt, c_done, c_rdata,
    output eep_addr, eep_wdata, eep_cs_n, eep_r_w_n, chrg_pmp_en, busy
`ifdef EEP_WR_VERIFY_EN
    , output wr_err
`endif
  );

  modport master (
    output p_req, p_addr, c_req, c_we, c_addr, c_wdata, eep_rdata,
    input  p_gnt, p_vld, p_rdata, c_gnt, c_done, c_rdata,
    input  eep_addr, eep_wdata, eep_cs_n, eep_r_w_n, chrg_pmp_en, busy
`ifdef EEP_WR_VERIFY_EN
    , input wr_err
`endif
  );

endinterface

// File: rtl/eep_arbiter_pmp.sv
// Charge-pump window timer. It is a free counter with a clear and an enable.
// tc is raised while the count equals TC_VAL.
module eep_pmp_timer #(
  parameter int unsigned       CNT_W  = 22,
  parameter logic [CNT_W-1:0]  TC_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/eep_arbiter.sv
// Shared-EEPROM access sequencer. It arbitrates between the PID loop, which only reads,
// and the command interpreter, which reads and writes. The loop has fixed priority.
// It times the charge-pump window for writes.
// Optional: EEP_WR_VERIFY_EN adds a one-cycle read-back (VFY) after each write and the wr_err flag.
module eep_arbiter
  import eep_arbiter_pkg::*;
#(
  parameter int unsigned CHRG_CYCLES = 22'h249F00,
  parameter int unsigned CNT_W       = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  eep_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CHRG_CYCLES - 1);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
`ifdef EEP_WR_VERIFY_EN
  logic              wr_err_q, wr_err_d;
`endif
  logic              pmp_clr, pmp_en, pmp_tc;

  // The counter stays cleared outside WR, so it reads 0 on the first WR cycle
  assign pmp_en  = (state_q == ST_WR);
  assign pmp_clr = !pmp_en;

  eep_pmp_timer #(
    .CNT_W  (CNT_W),
    .TC_VAL (TC_VAL)
  ) u_pmp_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pmp_clr),
    .en    (pmp_en),
    .tc    (pmp_tc)
  );

  // State and latch registers; an asynchronous reset aborts any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_q     <= SRC_LOOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      p_rdata_q <= '0;
      c_rdata_q <= '0;
`ifdef EEP_WR_VERIFY_EN
      wr_err_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      p_rdata_q <= p_rdata_d;
      c_rdata_q <= c_rdata_d;
`ifdef EEP_WR_VERIFY_EN
      wr_err_q  <= wr_err_d;
`endif
    end
  end

  // Next state: grant selection in IDLE, read-data capture in RD, and window exit in WR
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    p_rdata_d = p_rdata_q;
    c_rdata_d = c_rdata_q;
`ifdef EEP_WR_VERIFY_EN
    wr_err_d  = wr_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.p_req) begin
          src_d   = SRC_LOOP;
          addr_d  = bus.p_addr;
          state_d = ST_RD;
        end else if (bus.c_req) begin
          src_d   = SRC_CMD;
          addr_d  = bus.c_addr;
          wdata_d = bus.c_wdata;
          state_d = bus.c_we ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        if (src_q == SRC_LOOP) p_rdata_d = bus.eep_rdata;
        else                   c_rdata_d = bus.eep_rdata;
        state_d = ST_REC;
      end
      ST_WR: begin
        if (pmp_tc) begin
`ifdef EEP_WR_VERIFY_EN
          state_d = ST_VFY;
`else
          state_d = ST_REC;
`endif
        end
      end
`ifdef EEP_WR_VERIFY_EN
      ST_VFY: begin
        wr_err_d = (bus.eep_rdata != wdata_q);
        state_d  = ST_REC;
      end
`endif
      ST_REC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: Mealy grants in IDLE; the pin drive and completion pulses follow the current state
  always_comb begin
    bus.p_gnt       = 1'b0;
    bus.c_gnt       = 1'b0;
    bus.p_vld       = 1'b0;
    bus.c_done      = 1'b0;
    bus.eep_cs_n    = 1'b1;
    bus.eep_r_w_n   = 1'b1;
    bus.chrg_pmp_en = 1'b0;
    bus.eep_addr    = '0;
    bus.eep_wdata   = '0;
    case (state_q)
      ST_IDLE: begin
        bus.p_gnt = bus.p_req;
        bus.c_gnt = bus.c_req && !bus.p_req;
      end
      ST_RD: begin
        bus.eep_cs_n = 1'b0;
        bus.eep_addr = addr_q;
      end
      ST_WR: begin
        bus.eep_cs_n    = 1'b0;
        bus.eep_r_w_n   = 1'b0;
        bus.chrg_pmp_en = 1'b1;
        bus.eep_addr    = addr_q;
        bus.eep_wdata   = wdata_q;
      end
`ifdef EEP_WR_VERIFY_EN
      ST_VFY: begin
        bus.eep_cs_n = 1'b0;
        bus.eep_addr = addr_q;
      end
`endif
      ST_REC: begin
        bus.p_vld  = (src_q == SRC_LOOP);
        bus.c_done = (src_q == SRC_CMD);
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.p_rdata = p_rdata_q;
  assign bus.c_rdata = c_rdata_q;
`ifdef EEP_WR_VERIFY_EN
  assign bus.wr_err  = wr_err_q;
`endif

endmodule

// File: tb/tb_eep_arbiter.sv
// Self-checking bench for eep_arbiter (CHRG_CYCLES=8). A transaction-level model predicts
// every output on every cycle from the grant cycle and the offset into the operation.
// Directed scenarios add literal expectations. A randomized phase follows.
// Build with EEP_WR_VERIFY_EN to exercise the read-back path and wr_err.
module tb_eep_arbiter;
  import eep_arbiter_pkg::*;

  localparam int C = 8;
`ifdef EEP_WR_VERIFY_EN
  localparam bit VFY    = 1'b1;
  localparam int WR_LAT = C + 2;
`else
  localparam bit VFY    = 1'b0;
  localparam int WR_LAT = C + 1;
`endif
  localparam logic [13:0] INIT [4] = '{14'h2222, 14'h0123, 14'h0777, 14'h1555};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eep_arbiter_if bus();

  eep_arbiter #(.CHRG_CYCLES(C), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // EEPROM environment: the array commits only after a full charge-pump window
  logic [13:0] mem [4];
  bit          fault = 1'b0;
  int          pmp_run = 0;
  initial for (int i = 0; i < 4; i++) mem[i] <= INIT[i];
  assign bus.eep_rdata = fault ? 14'h0000 : mem[bus.eep_addr];
  always @(posedge clk) begin
    if (bus.chrg_pmp_en && !bus.eep_cs_n && !bus.eep_r_w_n) begin
      if (pmp_run == C - 1) mem[bus.eep_addr] <= bus.eep_wdata;
      pmp_run <= pmp_run + 1;
    end else begin
      pmp_run <= 0;
    end
  end

  // Reference model: one operation at a time, timed by its offset from the grant cycle
  initial begin : model
    int          cyc, off, m_start, m_kind;
    bit          m_act, end_op;
    logic [1:0]  m_addr;
    logic [13:0] m_wdata, m_prd, m_crd, rd;
    logic [13:0] sh [4];
    logic        m_err;
    logic        e_pg, e_cg, e_pv, e_cd, e_busy, e_cs, e_rw, e_pmp;
    logic [1:0]  e_addr;
    logic [13:0] e_wd;
    cyc = 0; m_act = 0; m_start = 0; m_kind = 0; m_addr = 0; m_wdata = 0;
    m_prd = 0; m_crd = 0; m_err = 0;
    for (int i = 0; i < 4; i++) sh[i] = INIT[i];
    forever begin
      @(negedge clk);
      e_pg = 0; e_cg = 0; e_pv = 0; e_cd = 0; e_busy = 0;
      e_cs = 1; e_rw = 1; e_pmp = 0; e_addr = 0; e_wd = 0; end_op = 0; off = 0;
      if (!rst_n) begin
        m_act = 0; m_prd = 0; m_crd = 0; m_err = 0;
      end else if (m_act) begin
        off = cyc - m_start;
        e_busy = 1;
        if (m_kind != 2) begin
          if (off == 1) begin
            e_cs = 0; e_addr = m_addr;
          end else begin
            if (m_kind == 0) e_pv = 1; else e_cd = 1;
            end_op = 1;
          end
        end else begin
          if (off <= C) begin
            e_cs = 0; e_rw = 0; e_pmp = 1; e_addr = m_addr; e_wd = m_wdata;
          end else if (VFY && off == C + 1) begin
            e_cs = 0; e_addr = m_addr;
          end else begin
            e_cd = 1; end_op = 1;
          end
        end
      end else begin
        if (bus.p_req) e_pg = 1;
        else if (bus.c_req) e_cg = 1;
      end
      chk("p_gnt", bus.p_gnt, e_pg);
      chk("c_gnt", bus.c_gnt, e_cg);
      chk("p_vld", bus.p_vld, e_pv);
      chk("c_done", bus.c_done, e_cd);
      chk("busy", bus.busy, e_busy);
      chk("eep_cs_n", bus.eep_cs_n, e_cs);
      chk("eep_r_w_n", bus.eep_r_w_n, e_rw);
      chk("chrg_pmp_en", bus.chrg_pmp_en, e_pmp);
      chk("eep_addr", bus.eep_addr, e_addr);
      chk("eep_wdata", bus.eep_wdata, e_wd);
      chk("p_rdata", bus.p_rdata, m_prd);
      chk("c_rdata", bus.c_rdata, m_crd);
`ifdef EEP_WR_VERIFY_EN
      chk("wr_err", bus.wr_err, m_err);
`endif
      // effects of the coming clock edge
      rd = fault ? 14'h0000 : sh[m_addr];
      if (m_act && m_kind != 2 && off == 1) begin
        if (m_kind == 0) m_prd = rd; else m_crd = rd;
      end
      if (m_act && m_kind == 2 && off == C) sh[m_addr] = m_wdata;
      if (m_act && m_kind == 2 && VFY && off == C + 1) m_err = (rd != m_wdata);
      if (end_op) m_act = 0;
      if (e_pg) begin
        m_act = 1; m_start = cyc; m_kind = 0; m_addr = bus.p_addr;
      end else if (e_cg) begin
        m_act = 1; m_start = cyc; m_kind = bus.c_we ? 2 : 1;
        m_addr = bus.c_addr; m_wdata = bus.c_wdata;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [13:0] d,
                          output int done_at, output int pmp_cnt);
    done_at = -1;
    pmp_cnt = 0;
    step();
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = a; bus.c_wdata = d;
    @(negedge clk);
    chk("wr_c_gnt", bus.c_gnt, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      step();
      bus.c_req = 1'b0;
      @(negedge clk);
      if (bus.chrg_pmp_en) begin
        pmp_cnt++;
        chk("wr_r_w_n", bus.eep_r_w_n, 1'b0);
        chk("wr_eep_wdata", bus.eep_wdata, d);
      end
      if (bus.c_done) begin
        done_at = k;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int done_at, pmp_cnt, gnt_at;
    bus.p_req = 0; bus.p_addr = 0; bus.c_req = 0; bus.c_we = 0;
    bus.c_addr = 0; bus.c_wdata = 0;
    #2;
    chk("rst_cs_n", bus.eep_cs_n, 1'b1);
    chk("rst_r_w_n", bus.eep_r_w_n, 1'b1);
    chk("rst_pmp", bus.chrg_pmp_en, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_p_rdata", bus.p_rdata, 14'h0);
    chk("rst_c_rdata", bus.c_rdata, 14'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();

    // loop read of ADDR_P
    step(); bus.p_req = 1; bus.p_addr = ADDR_P;
    @(negedge clk); chk("d1_p_gnt_N", bus.p_gnt, 1'b1);
    step(); bus.p_req = 0;
    @(negedge clk); chk("d1_cs_n_N1", bus.eep_cs_n, 1'b0);
    chk("d1_addr_N1", bus.eep_addr, 2'd1);
    step();
    @(negedge clk); chk("d1_p_vld_N2", bus.p_vld, 1'b1);
    chk("d1_p_rdata", bus.p_rdata, 14'h0123);

    // command write to ADDR_I
    do_write(ADDR_I, 14'h1ABC, done_at, pmp_cnt);
    chk("d2_pmp_cycles", pmp_cnt, C);
    chk("d2_done_at", done_at, WR_LAT);
`ifdef EEP_WR_VERIFY_EN
    chk("d2_wr_err", bus.wr_err, 1'b0);
`endif

    // simultaneous loop read and command read
    step(); bus.p_req = 1; bus.p_addr = ADDR_P;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = ADDR_I;
    @(negedge clk); chk("d3_p_gnt", bus.p_gnt, 1'b1); chk("d3_c_gnt_N", bus.c_gnt, 1'b0);
    step(); bus.p_req = 0;
    @(negedge clk);
    step();
    @(negedge clk); chk("d3_p_vld", bus.p_vld, 1'b1); chk("d3_c_done_early", bus.c_done, 1'b0);
    chk("d3_p_rdata", bus.p_rdata, 14'h0123);
    step();
    @(negedge clk); chk("d3_c_gnt_N3", bus.c_gnt, 1'b1);
    step(); bus.c_req = 0;
    @(negedge clk);
    step();
    @(negedge clk); chk("d3_c_done", bus.c_done, 1'b1); chk("d3_p_vld_late", bus.p_vld, 1'b0);
    chk("d3_c_rdata", bus.c_rdata, 14'h1ABC); chk("d3_p_rdata_kept", bus.p_rdata, 14'h0123);

    // loop request raised during a write
    step(); bus.c_req = 1; bus.c_we = 1; bus.c_addr = ADDR_D; bus.c_wdata = 14'h02A5;
    @(negedge clk); chk("d4_c_gnt", bus.c_gnt, 1'b1);
    done_at = -1; gnt_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      bus.c_req = 0;
      if (k == 3) begin bus.p_req = 1; bus.p_addr = ADDR_XSET; end
      @(negedge clk);
      if (bus.c_done) done_at = k;
      if (bus.p_gnt) begin gnt_at = k; break; end
    end
    chk("d4_done_at", done_at, WR_LAT);
    chk("d4_p_gnt_at", gnt_at, WR_LAT + 1);
    step(); bus.p_req = 0;
    repeat (3) step();

    // reset during the fourth write cycle
    step(); bus.c_req = 1; bus.c_we = 1; bus.c_addr = ADDR_XSET; bus.c_wdata = 14'h3FFF;
    @(negedge clk); chk("d5_c_gnt", bus.c_gnt, 1'b1);
    step(); bus.c_req = 0;
    repeat (3) step();
    #2;
    chk("d5_pmp_before", bus.chrg_pmp_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("d5_pmp_async", bus.chrg_pmp_en, 1'b0);
    chk("d5_cs_n_async", bus.eep_cs_n, 1'b1);
    chk("d5_busy_async", bus.busy, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("d5_no_c_done", bus.c_done, 1'b0);
      chk("d5_busy", bus.busy, 1'b0);
    end

`ifdef EEP_WR_VERIFY_EN
    // read-back against a failing EEPROM
    step(); fault = 1'b1;
    do_write(ADDR_P, 14'h0055, done_at, pmp_cnt);
    chk("d6_done_at", done_at, WR_LAT);
    chk("d6_wr_err", bus.wr_err, 1'b1);
    step(); fault = 1'b0;
    do_write(ADDR_P, 14'h0066, done_at, pmp_cnt);
    chk("d6_wr_err_clear", bus.wr_err, 1'b0);
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step();
      bus.p_req   = ($urandom_range(0, 2) == 0);
      bus.p_addr  = 2'($urandom);
      bus.c_req   = ($urandom_range(0, 3) == 0);
      bus.c_we    = 1'($urandom);
      bus.c_addr  = 2'($urandom);
      bus.c_wdata = 14'($urandom);
      fault       = ($urandom_range(0, 7) == 0);
    end
    step();
    bus.p_req = 0; bus.c_req = 0; fault = 0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
